// File: rtl/apb_master_bridge.sv
// Host-to-APB master bridge: one outstanding transfer, two slaves decoded by addr[7].
// Define APB_TIMEOUT_EN to abort an ACCESS phase after TIMEOUT wait cycles (rsp_err=1).
module apb_master_bridge #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic       PCLK,
  input  logic       PRESETn,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic       req_write,
  input  logic [7:0] req_addr,
  input  logic [7:0] req_wdata,
  output logic       rsp_valid,
  output logic [7:0] rsp_rdata,
  output logic       rsp_err,
  output logic       PSEL1,
  output logic       PSEL2,
  output logic       PENABLE,
  output logic       PWRITE,
  output logic [7:0] PADDR,
  output logic [7:0] PWDATA,
  input  logic [7:0] PRDATA1,
  input  logic [7:0] PRDATA2,
  input  logic       PREADY1,
  input  logic       PREADY2
);

  typedef enum logic [1:0] {StIdle, StSetup, StAccess} state_e;

  state_e     state_q;
  logic       sel_ready;
  logic [7:0] sel_rdata;

  if (TIMEOUT < 2 || TIMEOUT > 255) begin : g_bad_timeout
    $error("apb_master_bridge: TIMEOUT must be in 2..255");
  end

  // PADDR holds the captured address for the whole transfer, so bit 7 is the decode.
  assign sel_ready = PADDR[7] ? PREADY2 : PREADY1;
  assign sel_rdata = PADDR[7] ? PRDATA2 : PRDATA1;

`ifdef APB_TIMEOUT_EN
  localparam logic [7:0] Limit = 8'(TIMEOUT);
  logic [7:0] cnt_q;
`endif

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state_q   <= StIdle;
      req_ready <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_rdata <= 8'h00;
      rsp_err   <= 1'b0;
      PSEL1     <= 1'b0;
      PSEL2     <= 1'b0;
      PENABLE   <= 1'b0;
      PWRITE    <= 1'b0;
      PADDR     <= 8'h00;
      PWDATA    <= 8'h00;
`ifdef APB_TIMEOUT_EN
      cnt_q     <= 8'h00;
`endif
    end else begin
      rsp_valid <= 1'b0;
      rsp_rdata <= 8'h00;
      rsp_err   <= 1'b0;
      unique case (state_q)
        StIdle: begin
          // req_ready comes up one edge after reset release, then stays high while idle.
          if (req_valid && req_ready) begin
            state_q   <= StSetup;
            req_ready <= 1'b0;
            PADDR     <= req_addr;
            PWRITE    <= req_write;
            PWDATA    <= req_wdata;
            PSEL1     <= ~req_addr[7];
            PSEL2     <= req_addr[7];
          end else begin
            req_ready <= 1'b1;
          end
        end
        StSetup: begin
          state_q <= StAccess;
          PENABLE <= 1'b1;
`ifdef APB_TIMEOUT_EN
          cnt_q   <= 8'h00;
`endif
        end
        StAccess: begin
          if (sel_ready) begin
            state_q   <= StIdle;
            req_ready <= 1'b1;
            PSEL1     <= 1'b0;
            PSEL2     <= 1'b0;
            PENABLE   <= 1'b0;
            rsp_valid <= 1'b1;
            rsp_rdata <= PWRITE ? 8'h00 : sel_rdata;
          end
`ifdef APB_TIMEOUT_EN
          else if (cnt_q + 8'd1 == Limit) begin
            state_q   <= StIdle;
            req_ready <= 1'b1;
            PSEL1     <= 1'b0;
            PSEL2     <= 1'b0;
            PENABLE   <= 1'b0;
            rsp_valid <= 1'b1;
            rsp_err   <= 1'b1;
            cnt_q     <= 8'h00;
          end else begin
            cnt_q <= cnt_q + 8'd1;
          end
`endif
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: doc/apb_master_bridge.md
APB_MASTER_BRIDGE -- requirements
Module: apb_master_bridge

Interface
REQ-001 Parameter TIMEOUT, default 16, max ACCESS-phase wait cycles before abort (range 2..255).
REQ-002 PCLK  input  1  single clock, all logic on rising edge.
REQ-003 PRESETn  input  1  asynchronous active-low reset.
REQ-004 req_valid  input  1  host transfer request.
REQ-005 req_ready  output  1  bridge accepts request this cycle.
REQ-006 req_write  input  1  1=write, 0=read.
REQ-007 req_addr  input  8  transfer address.
REQ-008 req_wdata  input  8  write data.
REQ-009 rsp_valid  output  1  one-cycle completion pulse.
REQ-010 rsp_rdata  output  8  read data, valid with rsp_valid.
REQ-011 rsp_err  output  1  transfer aborted, valid with rsp_valid.
REQ-012 PSEL1, PSEL2  output  1 each  slave selects.
REQ-013 PENABLE, PWRITE  output  1 each  APB phase/direction.
REQ-014 PADDR, PWDATA  output  8 each  APB address/write data.
REQ-015 PRDATA1, PRDATA2  input  8 each  slave read data.
REQ-016 PREADY1, PREADY2  input  1 each  slave ready.

Function
REQ-017 FSM states IDLE, SETUP, ACCESS; req_ready SHALL be 1 only in IDLE.
REQ-018 Handshake req_valid&&req_ready SHALL register write/addr/wdata and move IDLE->SETUP.
REQ-019 SETUP: selected PSELx=1, PENABLE=0, PADDR/PWRITE/PWDATA driven from captured request; next state ACCESS unconditionally.
REQ-020 ACCESS: PSELx=1, PENABLE=1; PADDR/PWRITE/PWDATA/PSELx SHALL stay stable until exit.
REQ-021 Decode: req_addr[7]=0 selects slave 1 (PSEL1, PREADY1, PRDATA1); 1 selects slave 2; never both PSELs high.
REQ-022 ACCESS exits on rising edge where selected PREADY=1; unselected PREADY ignored.
REQ-023 On exit: next cycle rsp_valid=1 for exactly one cycle, rsp_err=0, rsp_rdata=selected PRDATA sampled at exit edge for reads, 0x00 for writes; state returns IDLE.
REQ-024 Latency: acceptance edge N, SETUP cycle N+1, ACCESS N+2; zero-wait transfer gives rsp_valid and req_ready=1 in cycle N+3.
REQ-025 Idle outputs: PSEL1=PSEL2=PENABLE=0; PADDR, PWDATA, PWRITE hold last values.
REQ-026 req_valid in non-IDLE states SHALL be ignored (not captured, not lost-flagged); host must hold it.
REQ-027 Back-to-back: request held across rsp_valid cycle is accepted in that same cycle (IDLE).

Reset
REQ-028 PRESETn low SHALL asynchronously force IDLE, all outputs 0, timeout counter 0.
REQ-029 Reset during SETUP/ACCESS SHALL drop PSELx/PENABLE immediately; no rsp_valid issued for the killed transfer.
REQ-030 First request accepted no earlier than first rising edge after PRESETn deasserts.

Configuration
REQ-031 Macro APB_TIMEOUT_EN defined: 8-bit counter clears on SETUP, increments each ACCESS cycle without PREADY; reaching TIMEOUT SHALL end transfer (PSELx/PENABLE to 0 next cycle), rsp_valid=1, rsp_err=1, rsp_rdata=0x00.
REQ-032 PREADY arriving on the same edge the counter reaches TIMEOUT SHALL win (normal completion, rsp_err=0).
REQ-033 Macro undefined: no counter, ACCESS waits indefinitely, rsp_err tied 0.

Verification
REQ-034 Write addr 0x05 data 0xA5, PREADY1 high in ACCESS -> PSEL1 high 2 cycles, PENABLE high 1 cycle, rsp_valid at N+3, rsp_err=0.
REQ-035 Read addr 0x05 after write, PRDATA1=0xA5 -> rsp_rdata=0xA5; repeat addr 0x85 with PRDATA2=0x3C -> PSEL2 only, rsp_rdata=0x3C.
REQ-036 PREADY2 held low 3 ACCESS cycles on addr 0x90 -> PADDR/PWDATA/PSEL2 stable throughout, rsp_valid 1 cycle after PREADY2 edge.
REQ-037 APB_TIMEOUT_EN, TIMEOUT=16, PREADY1 never asserted -> abort after 16 ACCESS cycles, rsp_err=1, rsp_rdata=0x00; PREADY on 16th cycle -> rsp_err=0.
REQ-038 PRESETn pulsed low mid-ACCESS -> PSEL1/PENABLE 0 without clock edge, no rsp_valid, req_ready=1 after release.
REQ-039 Two requests held back-to-back -> second accepted in first's rsp_valid cycle, SETUP follows next cycle.
